// File: rtl/apb_fabric_n.sv
// Registered APB fabric: one core initiator to TGT_N targets with base/mask decode,
// default error target, fault capture and optional PREADY watchdog (APB_FABRIC_TIMEOUT_EN).
//
// state  | meaning
// IDLE   | waiting for a core SETUP phase; captures and decodes the request
// SETUP  | target SETUP phase (psel=1, penable=0)
// ACCESS | target ACCESS phase, waiting for pready (or watchdog expiry)
// DERR   | decode miss, error response prepared, fault pulsed
// RESP   | core_i_pready high for one cycle with the registered response
module apb_fabric_n #(
  parameter int TGT_N = 4,
  parameter int ADDR_W = 34,
  parameter int TGT_ADDR_W = 31,
  parameter logic [TGT_N*ADDR_W-1:0] TGT_BASE = '0,
  parameter logic [TGT_N*ADDR_W-1:0] TGT_MASK = '0,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_i_psel,
  input  logic                  core_i_penable,
  input  logic                  core_i_pwrite,
  input  logic [ADDR_W-1:0]     core_i_paddr,
  input  logic [31:0]           core_i_pwdata,
  input  logic [3:0]            core_i_pwstrb,
  output logic                  core_i_pready,
  output logic [31:0]           core_i_prdata,
  output logic                  core_i_pslverr,
  output logic [TGT_N-1:0]      tgt_t_psel,
  output logic                  tgt_t_penable,
  output logic                  tgt_t_pwrite,
  output logic [TGT_ADDR_W-1:0] tgt_t_paddr,
  output logic [31:0]           tgt_t_pwdata,
  output logic [3:0]            tgt_t_pwstrb,
  input  logic [TGT_N-1:0]      tgt_t_pready,
  input  logic [TGT_N*32-1:0]   tgt_t_prdata,
  input  logic [TGT_N-1:0]      tgt_t_pslverr,
  output logic                  fault,
  output logic [ADDR_W-1:0]     fault_addr,
  output logic                  fault_timeout
);

  localparam int SEL_W = (TGT_N > 1) ? $clog2(TGT_N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DERR,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q;
  logic              req_write_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_strb_q;
  logic [SEL_W-1:0]  sel_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              fault_q;
  logic [ADDR_W-1:0] fault_addr_q;
  logic              fault_to_q;

  logic                  core_setup;
  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic [TGT_ADDR_W-1:0] sel_mask_lo;
  logic                  sel_ready;
  logic                  sel_err;
  logic [31:0]           sel_rdata;
  logic                  wdog_exp;

  assign core_setup = core_i_psel && !core_i_penable;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = TGT_N - 1; i >= 0; i--) begin
      if ((core_i_paddr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_mask_lo = '0;
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    sel_rdata   = '0;
    for (int i = 0; i < TGT_N; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_mask_lo = TGT_MASK[i*ADDR_W +: TGT_ADDR_W];
        sel_ready   = tgt_t_pready[i];
        sel_err     = tgt_t_pslverr[i];
        sel_rdata   = tgt_t_prdata[i*32 +: 32];
      end
    end
  end

`ifdef APB_FABRIC_TIMEOUT_EN
  logic [15:0] wdog_q;

  // wdog_q holds the number of ACCESS cycles already completed.
  assign wdog_exp = (wdog_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wdog_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      wdog_q <= wdog_q + 16'd1;
    end
  end
`else
  // TIMEOUT is at least 2, so this folds to a constant 0.
  assign wdog_exp = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_setup) begin
          state_d = dec_hit ? ST_SETUP : ST_DERR;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready || wdog_exp) begin
          state_d = ST_RESP;
        end
      end
      ST_DERR:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q   <= '0;
      req_write_q  <= 1'b0;
      req_wdata_q  <= '0;
      req_strb_q   <= '0;
      sel_q        <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_to_q   <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core_setup) begin
            req_addr_q  <= core_i_paddr;
            req_write_q <= core_i_pwrite;
            req_wdata_q <= core_i_pwdata;
            req_strb_q  <= core_i_pwstrb;
            sel_q       <= dec_sel;
            // Fault is raised here so it is visible during the DERR cycle.
            if (!dec_hit) begin
              rsp_rdata_q  <= '0;
              rsp_err_q    <= 1'b1;
              fault_q      <= 1'b1;
              fault_addr_q <= core_i_paddr;
              fault_to_q   <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            rsp_rdata_q <= req_write_q ? 32'd0 : sel_rdata;
            rsp_err_q   <= sel_err;
`ifdef APB_FABRIC_TIMEOUT_EN
          end else if (wdog_exp) begin
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b1;
            fault_q      <= 1'b1;
            fault_addr_q <= req_addr_q;
            fault_to_q   <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tgt_t_psel = '0;
    for (int i = 0; i < TGT_N; i++) begin
      tgt_t_psel[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (sel_q == SEL_W'(i));
    end
  end

  assign tgt_t_penable  = (state_q == ST_ACCESS);
  assign tgt_t_pwrite   = req_write_q;
  assign tgt_t_paddr    = req_addr_q[TGT_ADDR_W-1:0] & ~sel_mask_lo;
  assign tgt_t_pwdata   = req_wdata_q;
  assign tgt_t_pwstrb   = req_strb_q;

  assign core_i_pready  = (state_q == ST_RESP);
  assign core_i_prdata  = (state_q == ST_RESP) ? rsp_rdata_q : 32'd0;
  assign core_i_pslverr = (state_q == ST_RESP) && rsp_err_q;

  assign fault          = fault_q;
  assign fault_addr     = fault_addr_q;
  assign fault_timeout  = fault_to_q;

endmodule
